mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 1024, giving the number of 32-bit words; it SHALL be a power of two, at least 2.
REQ-002 The module SHALL have parameter LATENCY, default 4, giving the cycles from request acceptance to ready; it SHALL be at least 1.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port mem_req_addr, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-006 The module SHALL have port mem_wr_data, input, 32 bits: write data.
REQ-007 The module SHALL have port mem_req_vaild, input, 1 bit: request valid from the cache.
REQ-008 The module SHALL have port mem_req_wr, input, 1 bit: 1 = write, 0 = read.
REQ-009 The module SHALL have port mem_req_data, output, 32 bits: read data, registered.
REQ-010 The module SHALL have port mem_req_ready, output, 1 bit: one-cycle completion pulse, registered.
REQ-011 The module SHALL have port mem_req_err, output, 1 bit: out-of-range flag, valid while mem_req_ready is 1.

Function
REQ-012 The state machine SHALL have exactly these states: IDLE, BUSY, RESP, DRAIN.
REQ-013 In IDLE with mem_req_vaild=1, the module SHALL latch addr, wr and wdata at the clock edge, load the latency counter with LATENCY-1, and go to BUSY.
REQ-014 In BUSY, the counter SHALL decrement each cycle; at 0 the module SHALL go to RESP, so ready is high in the LATENCY-th cycle after the accepting edge.
REQ-015 In BUSY, changes on request inputs SHALL be ignored; only the latched values are used.
REQ-016 RESP SHALL last exactly one cycle, with mem_req_ready=1, then go to DRAIN.
REQ-017 DRAIN SHALL return to IDLE on the first cycle mem_req_vaild=0; a requester holding valid high SHALL NOT cause a second transaction.
REQ-018 Word index SHALL be addr[log2(DEPTH)+1:2].
REQ-019 An address is in range when addr[31:log2(DEPTH)+2] is all zero; otherwise mem_req_err=1 in the RESP cycle.
REQ-020 In-range read: mem_req_data SHALL equal the addressed word during RESP.
REQ-021 Write: the array SHALL update at the edge ending RESP; a read issued after that completes SHALL return the new data.
REQ-022 Out-of-range read SHALL return 32'hDEAD_BEEF; out-of-range write SHALL leave the array unchanged.
REQ-023 mem_req_data SHALL hold its last value until the next read's RESP; writes SHALL NOT change it.
REQ-024 mem_req_err SHALL be 0 outside RESP.
REQ-025 Array contents SHALL be zero at time 0 and SHALL NOT be affected by rst.

Reset
REQ-026 While rst=0, the module SHALL hold: state IDLE, mem_req_ready=0, mem_req_data=0, mem_req_err=0, counter 0.
REQ-027 When rst asserts during BUSY or RESP, the pending transaction SHALL be discarded, including a write not yet committed.
REQ-028 After rst deasserts, the first rising edge with mem_req_vaild=1 SHALL be accepted.

Verification
REQ-029 Reset, then read addr 0x10 with LATENCY=4 -> ready high exactly 4 cycles after the accepting edge, data 0, err 0.
REQ-030 Write 0x1234_5678 to 0x20, drop valid, then read 0x20 -> data 0x1234_5678, one ready pulse per transaction.
REQ-031 Hold valid high for 10 cycles after a read's RESP -> exactly one ready pulse; the next request is accepted only after valid drops.
REQ-032 Read 0x0000_1000 with DEPTH=1024 -> err=1, data 0xDEAD_BEEF; a write to that address leaves word 0 unchanged.
REQ-033 Assert rst two cycles into a write to 0x30 -> ready never pulses, outputs 0; a later read of 0x30 returns the old value.
REQ-034 Change addr and wdata mid-BUSY -> the response uses the values latched at acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory behind a request/ready handshake. Each accepted
// request completes after a fixed latency with a one-cycle ready pulse. A
// requester that keeps valid asserted is parked in DRAIN until it releases.
module mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_req_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_req_vaild,
    input  logic        mem_req_wr,
    output logic [31:0] mem_req_data,
    output logic        mem_req_ready,
    output logic        mem_req_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        DRAIN
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] idx_q;
    logic          in_range_q;
    logic          wr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   data_q;
    logic          ready_q;
    logic          err_q;

    // Storage starts cleared and is deliberately outside the reset domain.
    logic [31:0]   mem_q [DEPTH] = '{default: '0};

    logic [AW-1:0] req_idx_d;
    logic          req_in_range_d;
    logic [31:0]   rd_word_d;
    logic          unused_addr_lsbs;

    assign req_idx_d        = mem_req_addr[AW+1:2];
    assign req_in_range_d   = (mem_req_addr[31:AW+2] == '0);
    assign rd_word_d        = in_range_q ? mem_q[idx_q] : OOR_DATA;
    // Byte-lane bits carry no meaning for a word memory.
    assign unused_addr_lsbs = ^mem_req_addr[1:0];

    // Request sequencing: latch, count down the latency, pulse ready, drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_req_vaild) begin
                        idx_q      <= req_idx_d;
                        in_range_q <= req_in_range_d;
                        wr_q       <= mem_req_wr;
                        wdata_q    <= mem_wr_data;
                        cnt_q      <= CW'(LATENCY - 1);
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        // Outputs are registered here so they are valid for the whole RESP cycle.
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= ~in_range_q;
                        if (!wr_q) begin
                            data_q <= rd_word_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!mem_req_vaild) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Write commits on the edge that ends RESP; a reset before then drops it.
    always_ff @(posedge clk) begin
        if (state_q == RESP && wr_q && in_range_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_req_data  = data_q;
    assign mem_req_ready = ready_q;
    assign mem_req_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever ready is presented.
module tb_mem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned AW      = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_wr_data;
    logic        mem_req_vaild;
    logic        mem_req_wr;
    logic [31:0] mem_req_data;
    logic        mem_req_ready;
    logic        mem_req_err;

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_addr (mem_req_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_req_vaild(mem_req_vaild),
        .mem_req_wr   (mem_req_wr),
        .mem_req_data (mem_req_data),
        .mem_req_ready(mem_req_ready),
        .mem_req_err  (mem_req_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rd;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: reset values, err quiet outside a response, response contents and timing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            n_checks++;
            if (mem_req_ready !== 1'b0 || mem_req_err !== 1'b0 || mem_req_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d: ready=%b err=%b data=%h, required 0 0 00000000",
                         cyc, mem_req_ready, mem_req_err, mem_req_data);
            end
        end else if (mem_req_ready !== 1'b1) begin
            n_checks++;
            if (mem_req_err !== 1'b0 || mem_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_outputs cyc=%0d: ready=%b err=%b, required 0 0",
                         cyc, mem_req_ready, mem_req_err);
            end
        end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_ready cyc=%0d: ready=1 with no transaction outstanding", cyc);
        end else begin
            e = exp_q.pop_front();
            n_checks += 3;
            if (mem_req_data !== e.data) begin
                n_fail++;
                $display("FAIL resp_data cyc=%0d: got %h, expected %h", cyc, mem_req_data, e.data);
            end
            if (mem_req_err !== e.err) begin
                n_fail++;
                $display("FAIL resp_err cyc=%0d: got %b, expected %b", cyc, mem_req_err, e.err);
            end
            if (cyc != e.cyc) begin
                n_fail++;
                $display("FAIL resp_latency: ready at cycle %0d, expected cycle %0d", cyc, e.cyc);
            end
        end
    end

    // One transaction: hold keeps valid high for that many cycles past RESP;
    // scr randomizes all request inputs while the transaction is in flight.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input int unsigned hold, input bit scr);
        exp_t        e;
        bit          oor;
        bit          seen;
        int unsigned idx;
        @(negedge clk);
        mem_req_addr  = a;
        mem_req_wr    = w;
        mem_wr_data   = wd;
        mem_req_vaild = 1'b1;
        oor = ((a >> (AW + 2)) != 0);
        idx = (a >> 2) % DEPTH;
        if (!w) last_rd = oor ? 32'hDEAD_BEEF : model_mem[idx];
        e.data = last_rd;
        e.err  = oor;
        e.cyc  = cyc + 1 + LATENCY;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (hold == 0) mem_req_vaild = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4 * LATENCY + 10; k++) begin
            @(negedge clk);
            if (mem_req_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (scr) begin
                mem_req_addr = $urandom;
                mem_wr_data  = $urandom;
                mem_req_wr   = 1'($urandom_range(0, 1));
                if (hold == 0) mem_req_vaild = 1'($urandom_range(0, 1));
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ready_timeout addr=%h: no ready within %0d cycles, required one pulse",
                     a, 4 * LATENCY + 10);
            exp_q.delete();
        end else if (w && !oor) begin
            model_mem[idx] = wd;
        end
        if (hold > 0) begin
            mem_req_addr = a;
            mem_req_wr   = w;
            mem_wr_data  = wd;
            repeat (hold) @(negedge clk);
        end
        mem_req_vaild = 1'b0;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    // Write that is cut off by reset two cycles into BUSY; nothing may complete.
    task automatic do_abort(input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        mem_req_addr  = a;
        mem_req_wr    = 1'b1;
        mem_wr_data   = wd;
        mem_req_vaild = 1'b1;
        @(posedge clk);
        #1 mem_req_vaild = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        exp_q.delete();
        last_rd = 32'h0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
        last_rd       = 32'h0;
        mem_req_addr  = '0;
        mem_wr_data   = '0;
        mem_req_vaild = 1'b0;
        mem_req_wr    = 1'b0;
        rst           = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Read of untouched memory.
        do_txn(32'h0000_0010, 1'b0, 32'h0, 0, 1'b0);
        // Write then read back; the write response keeps the old read data.
        do_txn(32'h0000_0020, 1'b1, 32'h1234_5678, 0, 1'b0);
        do_txn(32'h0000_0020, 1'b0, 32'h0, 0, 1'b0);
        // Valid held long after RESP yields one pulse; next request follows.
        do_txn(32'h0000_0020, 1'b0, 32'h0, 10, 1'b0);
        do_txn(32'h0000_0024, 1'b0, 32'h0, 0, 1'b0);
        // Out of range read and write; word 0 must survive the aliasing write.
        do_txn(32'h0000_0000, 1'b1, 32'hA5A5_5A5A, 0, 1'b0);
        do_txn(32'h0000_1000, 1'b0, 32'h0, 0, 1'b0);
        do_txn(32'h0000_1000, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
        do_txn(32'h0000_0000, 1'b0, 32'h0, 0, 1'b0);
        // Reset mid-write discards the write.
        do_txn(32'h0000_0030, 1'b1, 32'hCAFE_0030, 0, 1'b0);
        do_abort(32'h0000_0030, 32'h0BAD_0BAD);
        do_txn(32'h0000_0030, 1'b0, 32'h0, 0, 1'b0);
        // Inputs churning during BUSY must not leak into the response.
        do_txn(32'h0000_0040, 1'b1, 32'h4040_4040, 0, 1'b1);
        do_txn(32'h0000_0040, 1'b0, 32'h0, 0, 1'b1);
        do_txn(32'h0000_0003, 1'b0, 32'h0, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
            do_txn(a, 1'($urandom_range(0, 1)), $urandom,
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
                   1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_responses: %0d outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
